muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters SHALL be, one per line:
  WIDTH, 32, operand/result width (>=8, even)
  MUL_LAT, 5, busy cycles for MULT/MULTU (>=1)
  DIV_LAT, 10, busy cycles for DIV/DIVU (>=1)
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock; all state changes on its rising edge
  reset  in  1  synchronous, active-high
  start  in  1  request strobe, sampled each rising edge
  MDOp  in  3  operation select
  A  in  WIDTH  operand A / dividend / move source
  B  in  WIDTH  operand B / divisor
  HI  out  WIDTH  HI register: product high half / remainder
  LO  out  WIDTH  LO register: product low half / quotient
  busy  out  1  multi-cycle operation in progress
  done  out  1  one-cycle pulse when HI/LO take a multi-cycle result
REQ-003 The one clock is clk; reset is synchronous and active-high, named reset.

Function
REQ-004 MDOp encodings: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 no-op.
REQ-005 A request is accepted only on an edge where start=1, busy=0, reset=0; otherwise start is ignored with no state change.
REQ-006 On acceptance of MULT/MULTU/DIV/DIVU, A, B and MDOp are captured; later input changes do not affect the result.
REQ-007 busy rises after the accepting edge and stays high exactly LAT cycles (MUL_LAT or DIV_LAT); at the LAT-th edge after acceptance HI/LO update, busy falls, done=1 for that one cycle.
REQ-008 HI/LO hold their previous values throughout busy; no partial results visible.
REQ-009 MULT: signed 2*WIDTH product; MULTU: unsigned; HI = upper WIDTH bits, LO = lower WIDTH bits.
REQ-010 DIV: signed, quotient truncated toward zero into LO, remainder (sign of dividend) into HI; DIVU: unsigned.
REQ-011 Divide by zero (DIV or DIVU): LO = all ones, HI = A; normal latency, no error flag.
REQ-012 DIV overflow (A = -2^(WIDTH-1), B = -1): LO = -2^(WIDTH-1), HI = 0.
REQ-013 MTHI/MTLO: HI (resp. LO) = A at the accepting edge; busy stays 0; done stays 0; other register unchanged.
REQ-014 Back-to-back: a new request is accepted on the edge immediately after busy falls (edge where busy=0 is sampled).
REQ-015 No-op encodings accepted with start=1 change nothing and do not assert busy.

Reset
REQ-016 When reset=1 at an edge: HI=0, LO=0, busy=0, done=0, latency counter and captured operands cleared.
REQ-017 Reset mid-operation aborts it; the pending result is never written and done does not pulse.
REQ-018 reset has priority over start on the same edge.

Structure
REQ-019 MDOp encodings and default latencies SHALL live in shared package muldiv_pkg, reused by the decoder.
REQ-020 Result is computed combinationally from captured operands into a staging value; a down-counter of width clog2(max(MUL_LAT,DIV_LAT))+1 sequences busy/done.
REQ-021 No sub-module is required; block is single module, states IDLE and BUSY only.

Verification (WIDTH=32, MUL_LAT=5, DIV_LAT=10)
REQ-022 MULT A=0xFFFFFFFE, B=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA, done pulses once.
REQ-023 MULTU A=0xFFFFFFFE, B=3 -> HI=0x00000002, LO=0xFFFFFFFA after 5 cycles.
REQ-024 DIV A=0xFFFFFFF9 (-7), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-025 DIVU A=0x00001234, B=0 -> LO=0xFFFFFFFF, HI=0x00001234; then MTHI A=0x55 -> HI=0x55 next edge, busy stays 0.
REQ-026 Start MULT, then during busy start MTLO A=0x99 and DIV -> both ignored; only MULT result written, LO != 0x99.
REQ-027 DIV started, reset asserted 4 cycles later -> next cycle HI=LO=0, busy=0, no done pulse at cycle 10.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared operation encodings, FSM states and default latencies for the
// multiply/divide unit and its operation decoder.
package muldiv_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'b000,
      MD_MULTU = 3'b001,
      MD_DIV   = 3'b010,
      MD_DIVU  = 3'b011,
      MD_MTHI  = 3'b100,
      MD_MTLO  = 3'b101,
      MD_NOP6  = 3'b110,
      MD_NOP7  = 3'b111
   } mdop_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   localparam int DEF_MUL_LAT = 5;
   localparam int DEF_DIV_LAT = 10;

   function automatic int max_lat(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit: operands are captured on acceptance,
// the result is staged combinationally and committed when the latency counter expires.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = DEF_MUL_LAT,
   parameter int DIV_LAT = DEF_DIV_LAT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       MDOp,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(max_lat(MUL_LAT, DIV_LAT)) + 1;

   localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
   localparam logic [CW-1:0]    ZERO_C = {CW{1'b0}};
   localparam logic [CW-1:0]    ONE_C  = {{(CW-1){1'b0}}, 1'b1};

   state_e           state_r;
   logic [CW-1:0]    cnt_r;
   mdop_e            op_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;

   mdop_e              op_s;
   logic               sgn_s;
   logic               a_neg_s;
   logic               b_neg_s;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   a_mag_s;
   logic [WIDTH-1:0]   b_mag_s;
   logic [WIDTH-1:0]   q_mag_s;
   logic [WIDTH-1:0]   r_mag_s;
   logic [WIDTH-1:0]   hi_s;
   logic [WIDTH-1:0]   lo_s;

   assign op_s = mdop_e'(MDOp);

   // Staging value: result of the captured operation, committed only on completion
   always_comb begin
      sgn_s   = (op_r == MD_MULT) || (op_r == MD_DIV);
      a_neg_s = sgn_s & a_r[WIDTH-1];
      b_neg_s = sgn_s & b_r[WIDTH-1];
      // Sign-extending to 2*WIDTH makes the unsigned product exact for signed inputs too
      prod_s  = {{WIDTH{a_neg_s}}, a_r} * {{WIDTH{b_neg_s}}, b_r};
      a_mag_s = a_neg_s ? (ZERO_W - a_r) : a_r;
      b_mag_s = b_neg_s ? (ZERO_W - b_r) : b_r;
      q_mag_s = (b_mag_s == ZERO_W) ? ZERO_W : (a_mag_s / b_mag_s);
      r_mag_s = (b_mag_s == ZERO_W) ? ZERO_W : (a_mag_s % b_mag_s);
      hi_s    = HI;
      lo_s    = LO;
      case (op_r)
         MD_MULT, MD_MULTU: begin
            hi_s = prod_s[2*WIDTH-1:WIDTH];
            lo_s = prod_s[WIDTH-1:0];
         end
         MD_DIV, MD_DIVU: begin
            // Magnitude divide covers -2^(W-1)/-1 naturally: quotient wraps to -2^(W-1), remainder 0
            if (b_r == ZERO_W) begin
               hi_s = a_r;
               lo_s = ONES_W;
            end else begin
               hi_s = a_neg_s ? (ZERO_W - r_mag_s) : r_mag_s;
               lo_s = (a_neg_s ^ b_neg_s) ? (ZERO_W - q_mag_s) : q_mag_s;
            end
         end
         default: begin
            hi_s = HI;
            lo_s = LO;
         end
      endcase
   end

   // IDLE/BUSY sequencer, operand capture and HI/LO register file
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= ZERO_C;
         op_r    <= MD_MULT;
         a_r     <= ZERO_W;
         b_r     <= ZERO_W;
         HI      <= ZERO_W;
         LO      <= ZERO_W;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  case (op_s)
                     MD_MULT, MD_MULTU: begin
                        op_r    <= op_s;
                        a_r     <= A;
                        b_r     <= B;
                        cnt_r   <= CW'(MUL_LAT);
                        busy    <= 1'b1;
                        state_r <= ST_BUSY;
                     end
                     MD_DIV, MD_DIVU: begin
                        op_r    <= op_s;
                        a_r     <= A;
                        b_r     <= B;
                        cnt_r   <= CW'(DIV_LAT);
                        busy    <= 1'b1;
                        state_r <= ST_BUSY;
                     end
                     MD_MTHI: HI <= A;
                     MD_MTLO: LO <= A;
                     default: ;
                  endcase
               end
            end
            ST_BUSY: begin
               if (cnt_r == ONE_C) begin
                  HI      <= hi_s;
                  LO      <= lo_s;
                  cnt_r   <= ZERO_C;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_r <= ST_IDLE;
               end else begin
                  cnt_r <= cnt_r - ONE_C;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit: expected HI/LO pairs are queued at
// issue time and checked by a monitor whenever done pulses.
module tb_muldiv_unit;

   localparam int W  = 32;
   localparam int ML = 5;
   localparam int DL = 10;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [2:0]   MDOp;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [W-1:0] HI;
   logic [W-1:0] LO;
   logic         busy;
   logic         done;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
      .clk(clk), .reset(reset), .start(start), .MDOp(MDOp),
      .A(A), .B(B), .HI(HI), .LO(LO), .busy(busy), .done(done)
   );

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } res_t;

   res_t         exp_q[$];
   int           checks   = 0;
   int           failures = 0;
   logic [W-1:0] m_hi;
   logic [W-1:0] m_lo;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain arithmetic on the architectural HI/LO contents
   function automatic res_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      res_t        r;
      logic [63:0] p;
      longint      sa;
      longint      sb;
      int          ia;
      int          ib;
      r.hi = m_hi;
      r.lo = m_lo;
      case (op)
         3'd0: begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p  = sa * sb;
            r.hi = p[63:32];
            r.lo = p[31:0];
         end
         3'd1: begin
            p = {32'd0, a} * {32'd0, b};
            r.hi = p[63:32];
            r.lo = p[31:0];
         end
         3'd2: begin
            if (b == 32'd0) begin
               r.hi = a; r.lo = 32'hFFFF_FFFF;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               r.hi = 32'd0; r.lo = 32'h8000_0000;
            end else begin
               ia = $signed(a);
               ib = $signed(b);
               r.lo = ia / ib;
               r.hi = ia % ib;
            end
         end
         3'd3: begin
            if (b == 32'd0) begin
               r.hi = a; r.lo = 32'hFFFF_FFFF;
            end else begin
               r.lo = a / b;
               r.hi = a % b;
            end
         end
         3'd4: r.hi = a;
         3'd5: r.lo = a;
         default: ;
      endcase
      return r;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin : monitor
      res_t e;
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done=1 expected no pending result");
         end else begin
            e = exp_q.pop_front();
            chk("mon_hi", HI, e.hi);
            chk("mon_lo", LO, e.lo);
         end
      end
   end

   // Called at a negedge; returns at the negedge where the result is visible.
   task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit inject);
      res_t e;
      bit   got;
      int   nb;
      int   lat;
      e   = model(op, a, b);
      lat = (op < 3'd2) ? ML : DL;
      MDOp = op; A = a; B = b; start = 1'b1;
      if (op < 3'd4) begin
         exp_q.push_back(e);
         got = 1'b0;
         nb  = 0;
         for (int i = 0; i < DL + 6 && !got; i++) begin
            @(negedge clk);
            if (done) begin
               got = 1'b1;
            end else begin
               if (busy) nb++;
               chk("hold_hi", HI, m_hi);
               chk("hold_lo", LO, m_lo);
            end
            if (inject && i == 0) begin
               start = 1'b1; MDOp = 3'd5; A = 32'h99;
            end else if (inject && i == 1) begin
               start = 1'b1; MDOp = 3'd2; A = $urandom; B = $urandom;
            end else begin
               start = 1'b0; MDOp = 3'($urandom_range(0, 7)); A = $urandom; B = $urandom;
            end
         end
         chk("done_seen", W'(got), W'(1));
         chk("busy_cycles", W'(nb), W'(lat));
      end else begin
         @(negedge clk);
         start = 1'b0; MDOp = 3'($urandom_range(0, 7)); A = $urandom; B = $urandom;
         chk("move_hi", HI, e.hi);
         chk("move_lo", LO, e.lo);
         chk("move_busy", W'(busy), W'(0));
         chk("move_done", W'(done), W'(0));
      end
      m_hi = e.hi;
      m_lo = e.lo;
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 6))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return W'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      m_hi = 32'd0;
      m_lo = 32'd0;
      // Reset wins over a simultaneous MTHI request
      reset = 1'b1; start = 1'b1; MDOp = 3'd4; A = 32'h77; B = 32'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0; start = 1'b0;
      chk("rst_hi", HI, 32'd0);
      chk("rst_lo", LO, 32'd0);
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_done", W'(done), W'(0));

      run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
      chk("mult_hi", HI, 32'hFFFF_FFFF);
      chk("mult_lo", LO, 32'hFFFF_FFFA);
      run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
      chk("multu_hi", HI, 32'h0000_0002);
      chk("multu_lo", LO, 32'hFFFF_FFFA);
      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
      chk("div_hi", HI, 32'hFFFF_FFFF);
      chk("div_lo", LO, 32'hFFFF_FFFD);
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      chk("divovf_hi", HI, 32'd0);
      chk("divovf_lo", LO, 32'h8000_0000);
      run_op(3'd3, 32'h0000_1234, 32'd0, 1'b0);
      chk("div0_hi", HI, 32'h0000_1234);
      chk("div0_lo", LO, 32'hFFFF_FFFF);
      run_op(3'd4, 32'h55, 32'd0, 1'b0);
      chk("mthi_hi", HI, 32'h55);
      chk("mthi_lo", LO, 32'hFFFF_FFFF);
      run_op(3'd0, 32'd7, 32'd6, 1'b1);
      chk("ignored_hi", HI, 32'd0);
      chk("ignored_lo", LO, 32'h2A);
      run_op(3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0);
      run_op(3'd7, 32'hCAFE_F00D, 32'd2, 1'b0);

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
         run_op(3'($urandom_range(0, 7)), pick(), pick(), 1'b0);
      end

      // Reset four edges into a divide: result must never appear
      MDOp = 3'd2; A = 32'd100; B = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_hi = 32'd0;
      m_lo = 32'd0;
      chk("abort_hi", HI, 32'd0);
      chk("abort_lo", LO, 32'd0);
      chk("abort_busy", W'(busy), W'(0));
      for (int i = 0; i < DL + 2; i++) begin
         chk("abort_no_done", W'(done), W'(0));
         @(negedge clk);
      end

      run_op(3'd1, $urandom, $urandom, 1'b0);
      run_op(3'd2, $urandom, W'($urandom_range(1, 9)), 1'b0);
      repeat (3) @(negedge clk);
      chk("queue_empty", W'(exp_q.size()), W'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
